dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Round-robin load/store arbiter directly upstream of the single-port 16-bit data memory. Accepts word read/write requests from `NUM_CH` core load/store channels, serializes them onto the memory's one address/write-data/write-enable port, and returns read data or write acknowledgements to the requesting channel. One transaction is in flight at a time. The memory port matches the data memory: combinational read of `mem_rdata` from `mem_addr`, write committed at the clock edge while `mem_write` is high.

## Interface
- `NUM_CH`, 4: number of requesting channels, ≥1 (not restricted to powers of two)
- `ADDR_W`, 16: request/memory address width
- `DATA_W`, 16: data width
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-low (state cleared on an edge where `reset`=0)
- `req_valid` in NUM_CH: per-channel request valid
- `req_write` in NUM_CH: per-channel 1=store, 0=load
- `req_addr` in NUM_CH*ADDR_W: channel i at bits [i*ADDR_W +: ADDR_W]
- `req_wdata` in NUM_CH*DATA_W: channel i at bits [i*DATA_W +: DATA_W]
- `req_ready` out NUM_CH: one-hot accept; request i is accepted on an edge where `req_valid[i]` & `req_ready[i]`
- `resp_valid` out NUM_CH: one-hot response valid
- `resp_rdata` out DATA_W: load data for the channel flagged in `resp_valid`; 0 for store acks
- `resp_ready` in NUM_CH: per-channel response accept
- `mem_addr` out ADDR_W: memory address (memory decodes low bits)
- `mem_wd` out DATA_W: memory write data
- `mem_write` out 1: memory write enable
- `mem_rdata` in DATA_W: combinational memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Registers: `state`, `ptr` (clog2(NUM_CH) bits, min 1), latched `grant` index, `op_write`, `op_addr`, `op_wdata`, `rdata_q`.
- IDLE: grant = first i with `req_valid[i]`=1, searching i = ptr, ptr+1, … wrapping mod NUM_CH. `req_ready[grant]`=1 combinationally, all other bits 0. No valid requests: `req_ready`=0 and the FSM stays in IDLE. On accept, latch write flag, address and write data into the op registers, and go to ACCESS.
- ACCESS: `mem_addr`=`op_addr`, `mem_wd`=`op_wdata`, `mem_write`=`op_write` for exactly this one cycle. Loads capture `rdata_q` ← `mem_rdata`. Stores capture `rdata_q` ← 0. Next state is RESP.
- RESP: `resp_valid[grant]`=1, `resp_rdata`=`rdata_q`. Hold both until `resp_ready[grant]`=1. On that edge, set `ptr` ← (grant+1) mod NUM_CH and return to IDLE.
- `req_ready`=0 in ACCESS and RESP. `resp_valid`=0 outside RESP.
- `mem_write`=0 outside ACCESS. `mem_addr`/`mem_wd` always reflect the op registers (stable outside ACCESS).
- Request payload is sampled only at accept. A channel may change or drop its request afterwards without effect.
- Bits of `resp_ready` for non-granted channels are ignored.

## Timing
- Reset (`reset`=0 at an edge): state=IDLE, ptr=0, op registers and `rdata_q`=0.
- While `reset`=0, combinational `req_ready` is forced to 0. After reset, all outputs are 0.
- Reset mid-operation: the transaction in flight is abandoned with no response. If reset is sampled during ACCESS, `mem_write` is forced to 0 that cycle, so the store is not committed.
- Latency: accept at edge T, ACCESS during cycle T..T+1, `resp_valid` high from edge T+1. Minimum 3 cycles per transaction (accept, access, response with `resp_ready` already high).
- Next accept earliest on the edge after the response handshake. No back-to-back overlap.
- Fairness: after serving channel g, channel g+1 (mod NUM_CH) has top priority. With all channels requesting continuously, each is served once per NUM_CH transactions.
- Load-after-store to the same address returns the stored value: the store commits at the end of its ACCESS cycle, before the next ACCESS.
- `NUM_CH`=1: ptr stays 0, and the arbiter degenerates to a 3-state sequencer.

## Test plan
- Single load: memory preloaded [0x12]=0xBEEF; ch0 load addr 0x0012 → `req_ready[0]` in the same cycle, `mem_write`=0, `resp_valid[0]` with `resp_rdata`=0xBEEF two edges later.
- Store then load: ch2 stores 0xA5A5 to 0x0040, then loads 0x0040 → `mem_write` high exactly one cycle with `mem_addr`=0x0040, store ack `resp_rdata`=0, load returns 0xA5A5.
- Contention and wrap: all 4 channels continuously valid from reset → grant order 0,1,2,3,0,1 and ptr wraps 3→0.
- Skip idle channels: ptr=2 with only ch1 and ch3 valid → ch3 served first, then ch1.
- Backpressure: `resp_ready[1]` low for 5 cycles → `resp_valid[1]`/`resp_rdata` stable for 5 cycles, `req_ready` stays 0 although other channels are valid, and the next grant follows release.
- Reset mid-store: assert `reset`=0 in the ACCESS cycle of a store of 0x1111 to 0x0005 → `mem_write` is 0, [0x05] is unchanged, no `resp_valid`, and ptr=0 afterwards.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter in front of the single-port data memory. Serializes
//   word loads/stores from NUM_CH channels onto one memory port, one
//   transaction in flight at a time, and returns load data or a store ack
//   to the requesting channel.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   req_valid/write   per-channel request valid / 1=store, 0=load
//   req_addr/wdata    per-channel payload, channel i at [i*W +: W]
//   req_ready         one-hot accept (combinational, IDLE only)
//   resp_valid        one-hot response valid (RESP only)
//   resp_rdata        load data, 0 for store acks
//   resp_ready        per-channel response accept (granted bit only)
//   mem_addr/mem_wd   memory address / write data (from op registers)
//   mem_write         memory write enable (ACCESS only)
//   mem_rdata         combinational memory read data
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | search for a valid request from ptr upward, accept it
// ACCESS | drive memory port for one cycle, capture read data
// RESP   | present response to granted channel until it is accepted
module dmem_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  input  logic [NUM_CH-1:0]        resp_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wd,
  output logic                     mem_write,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    grant;
  logic                op_write;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic [DATA_W-1:0]   rdata_q;

  logic                found;
  logic [PTR_W-1:0]    sel;
  int                  cand;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                accept;
  logic [PTR_W-1:0]    ptr_next;

  // Circular priority search starting at ptr; modulo keeps it correct for
  // channel counts that are not powers of two.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (int'(ptr) + k) % NUM_CH;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    sel_addr  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[int'(sel)*DATA_W +: DATA_W];
  end

  // Accept is blocked while reset is asserted so nothing is handed off on
  // an edge that clears the FSM.
  assign accept = (state == IDLE) && reset && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[sel] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[grant] = 1'b1;
  end

  assign resp_rdata = (state == RESP) ? rdata_q : '0;
  assign mem_addr   = op_addr;
  assign mem_wd     = op_wdata;
  // Gating with reset keeps a store abandoned by reset from committing.
  assign mem_write  = (state == ACCESS) && op_write && reset;

  assign ptr_next = (grant == PTR_W'(NUM_CH - 1)) ? '0 : grant + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      op_write <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= sel;
            op_write <= req_write[sel];
            op_addr  <= sel_addr;
            op_wdata <= sel_wdata;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= op_write ? '0 : mem_rdata;
          state   <= RESP;
        end
        RESP: begin
          if (resp_ready[grant]) begin
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] req_valid;
  logic [NC-1:0] req_write;
  logic [NC*16-1:0] req_addr;
  logic [NC*16-1:0] req_wdata;
  logic [NC-1:0] req_ready;
  logic [NC-1:0] resp_valid;
  logic [15:0]   resp_rdata;
  logic [NC-1:0] resp_ready;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_wd;
  logic          mem_write;
  logic [15:0]   mem_rdata;

  logic [15:0]   ch_addr  [NC];
  logic [15:0]   ch_wdata [NC];

  // Environment memory (low 8 address bits decoded) plus preload port.
  logic [15:0]   mem [256];
  logic          pl_en;
  logic [7:0]    pl_a;
  logic [15:0]   pl_d;

  // Reference model state: transaction-level memory and priority pointer.
  logic [15:0]   ref_mem [256];
  int            ref_ptr;

  int            n_checks;
  int            n_errors;

  dmem_arbiter #(.NUM_CH(NC), .ADDR_W(16), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_ready (resp_ready),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int k = 0; k < NC; k++) begin
      req_addr[k*16 +: 16]  = ch_addr[k];
      req_wdata[k*16 +: 16] = ch_wdata[k];
    end
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (mem_write) mem[mem_addr[7:0]] <= mem_wd;
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic set_ch(input int c, input logic w, input logic [15:0] a, input logic [15:0] d);
    req_write[c] = w;
    ch_addr[c]   = a;
    ch_wdata[c]  = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '1;
    @(posedge clk); #1;
    check("rst_req_ready_forced", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b1;
    #1;
    check("rst_req_ready",  32'(req_ready),  32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'h0);
    check("rst_mem_addr",   32'(mem_addr),   32'h0);
    check("rst_mem_wd",     32'(mem_wd),     32'h0);
    check("rst_mem_write",  32'(mem_write),  32'h0);
    ref_ptr = 0;
  endtask

  // One transaction from IDLE (called just after a rising edge). Expected
  // grant comes from the round-robin rule; expected data from ref_mem.
  task automatic run_txn(input logic [NC-1:0] vmask, input int stall);
    int          g;
    logic [NC-1:0] oh;
    logic        ewr;
    logic [15:0] ea, ew, er;
    g = -1;
    for (int k = 0; k < NC; k++)
      if (g < 0 && vmask[(ref_ptr + k) % NC]) g = (ref_ptr + k) % NC;
    req_valid = vmask;
    if (g < 0) begin
      #1;
      check("idle_no_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      check("idle_no_resp", 32'(resp_valid), 32'h0);
      check("idle_no_write", 32'(mem_write), 32'h0);
      return;
    end
    oh = NC'(1 << g);
    resp_ready = (stall == 0) ? '1 : ~oh;
    #1;
    check("grant_req_ready", 32'(req_ready), 32'(oh));
    check("idle_resp_valid", 32'(resp_valid), 32'h0);
    check("idle_mem_write", 32'(mem_write), 32'h0);
    ewr = req_write[g]; ea = ch_addr[g]; ew = ch_wdata[g];
    @(posedge clk); #1;
    // Change every request after accept; the op must not follow.
    req_valid = NC'($urandom);
    for (int k = 0; k < NC; k++)
      set_ch(k, 1'($urandom), 16'($urandom), 16'($urandom));
    #1;
    check("acc_req_ready", 32'(req_ready), 32'h0);
    check("acc_mem_write", 32'(mem_write), 32'(ewr));
    check("acc_mem_addr",  32'(mem_addr),  32'(ea));
    check("acc_mem_wd",    32'(mem_wd),    32'(ew));
    check("acc_resp_valid", 32'(resp_valid), 32'h0);
    if (ewr) ref_mem[ea[7:0]] = ew;
    er = ewr ? 16'h0 : ref_mem[ea[7:0]];
    @(posedge clk); #1;
    req_valid = '1;
    #1;
    check("resp_valid",    32'(resp_valid), 32'(oh));
    check("resp_rdata",    32'(resp_rdata), 32'(er));
    check("resp_req_ready", 32'(req_ready), 32'h0);
    check("resp_mem_write", 32'(mem_write), 32'h0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_resp_valid", 32'(resp_valid), 32'(oh));
      check("stall_resp_rdata", 32'(resp_rdata), 32'(er));
      check("stall_req_ready",  32'(req_ready),  32'h0);
    end
    resp_ready = '1;
    @(posedge clk); #1;
    check("post_resp_valid", 32'(resp_valid), 32'h0);
    ref_ptr = (g + 1) % NC;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; ref_ptr = 0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    reset = 1'b0;
    req_valid = '0; req_write = '0; resp_ready = '0;
    for (int k = 0; k < NC; k++) begin ch_addr[k] = '0; ch_wdata[k] = '0; end
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    @(posedge clk); #1;
    preload(8'h12, 16'hBEEF);
    preload(8'h05, 16'h7777);
    do_reset();

    // Single load on ch0.
    set_ch(0, 1'b0, 16'h0012, 16'h0000);
    run_txn(4'b0001, 0);

    // Store then load on ch2.
    set_ch(2, 1'b1, 16'h0040, 16'hA5A5);
    run_txn(4'b0100, 0);
    set_ch(2, 1'b0, 16'h0040, 16'h0000);
    run_txn(4'b0100, 0);

    // Contention from reset: grant order 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NC; k++) set_ch(k, 1'b0, 16'(8'h10 + k), 16'h0);
      run_txn(4'b1111, 0);
    end

    // ptr=2, only ch1 and ch3 valid: ch3 then ch1.
    for (int i = 0; i < 2; i++) begin
      set_ch(1, 1'b1, 16'h0021, 16'h1234);
      set_ch(3, 1'b0, 16'h0021, 16'h0000);
      run_txn(4'b1010, 0);
    end

    // Backpressure on ch1, then next grant follows release.
    set_ch(1, 1'b0, 16'h0021, 16'h0000);
    run_txn(4'b0010, 5);
    for (int k = 0; k < NC; k++) set_ch(k, 1'b0, 16'h0040, 16'h0);
    run_txn(4'b1111, 0);

    // Reset during ACCESS of a store on ch3 (ptr=3).
    set_ch(3, 1'b1, 16'h0005, 16'h1111);
    req_valid = 4'b1000;
    #1;
    check("rst_store_grant", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_store_mem_write", 32'(mem_write), 32'h0);
    @(posedge clk); #1;
    check("rst_store_no_resp", 32'(resp_valid), 32'h0);
    check("rst_store_mem_kept", 32'(mem[8'h05]), 32'h7777);
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b1;
    #1;
    check("rst_store_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_store_no_resp2", 32'(resp_valid), 32'h0);
    ref_ptr = 0;
    for (int k = 0; k < NC; k++) set_ch(k, 1'b0, 16'h0005, 16'h0);
    run_txn(4'b1111, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < NC; k++)
        set_ch(k, 1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom));
      run_txn(NC'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
